// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit for the EX stage.
// It handles one bit per cycle, using shift-add multiply and restoring divide.
// Every operation takes DATA_WIDTH+2 cycles after the latch cycle, including
// divide by zero.
//
// Ports
//   CPU_CLK    clock, rising edge
//   CPU_RST    synchronous active-low reset
//   StartE     M-extension instruction valid in EX
//   Fn3E       funct3 op select (MUL..REMU)
//   Op1E/Op2E  rs1/rs2 after forwarding
//   FlushE     abort any operation, return to IDLE
//   StallMdE   hold IF/ID/EX while busy (combinational)
//   DoneE      one-cycle pulse, MdResultE valid
//   MdResultE  registered result
module muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST,
  input  logic                  StartE,
  input  logic [2:0]            Fn3E,
  input  logic [DATA_WIDTH-1:0] Op1E,
  input  logic [DATA_WIDTH-1:0] Op2E,
  input  logic                  FlushE,
  output logic                  StallMdE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] MdResultE
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state, state_nxt;
  logic            start;
  logic [2:0]      fn3;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;   // mul: {hi, multiplier}; div: {rem, quot}
  logic [W-1:0]    opd;   // multiplicand or divisor magnitude
  logic            neg;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Operand decode at latch time
  logic         sgn1, sgn2, s1, s2, is_div, dz, neg_lat;
  logic [W-1:0] mag1, mag2;

  always_comb begin
    sgn1    = (Fn3E == F_MULH) || (Fn3E == F_MULHSU) || (Fn3E == F_DIV) || (Fn3E == F_REM);
    sgn2    = (Fn3E == F_MULH) || (Fn3E == F_DIV) || (Fn3E == F_REM);
    s1      = sgn1 & Op1E[W-1];
    s2      = sgn2 & Op2E[W-1];
    is_div  = Fn3E[2];
    dz      = (Op2E == '0);
    // Remainder takes the dividend's sign; product/quotient take the xor.
    neg_lat = (is_div && dz) ? 1'b0 : ((Fn3E[2] & Fn3E[1]) ? s1 : (s1 ^ s2));
    // With a zero divisor the raw dividend shifts straight through into the
    // remainder while every quotient bit sets, giving all-ones / Op1.
    mag1    = (is_div && dz) ? Op1E : neg_w(Op1E, s1);
    mag2    = neg_w(Op2E, s2);
  end

  // One iteration of each datapath, plus sign fix and result select
  logic [W:0]     mul_sum, rem_sh;
  logic           ge;
  logic [W-1:0]   rem_nx;
  logic [2*W-1:0] acc_mul, acc_div, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, res_sel;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
    acc_mul  = {mul_sum, acc[W-1:1]};
    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    ge       = (rem_sh >= {1'b0, opd});
    rem_nx   = ge ? W'(rem_sh - {1'b0, opd}) : rem_sh[W-1:0];
    acc_div  = {rem_nx, acc[W-2:0], ge};
    prod_fix = neg_2w(acc, neg);
    quot_fix = neg_w(acc[W-1:0], neg);
    rem_fix  = neg_w(acc[2*W-1:W], neg);
    case (fn3)
      F_MUL:          res_sel = prod_fix[W-1:0];
      3'b001, 3'b010,
      3'b011:         res_sel = prod_fix[2*W-1:W];
      3'b100, 3'b101: res_sel = quot_fix;
      default:        res_sel = rem_fix;
    endcase
  end

  // Control: next state and handshake outputs
  always_comb begin
    state_nxt = state;
    StallMdE  = 1'b0;
    DoneE     = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: if (StartE) begin
        StallMdE  = 1'b1;
        start     = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        StallMdE = 1'b1;
        if (cnt == CW'(1)) state_nxt = SIGN;
      end
      SIGN: begin
        StallMdE  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        DoneE     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (FlushE || !CPU_RST) begin
      state_nxt = IDLE;
      StallMdE  = 1'b0;
      DoneE     = 1'b0;
      start     = 1'b0;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST) begin
      state     <= IDLE;
      fn3       <= '0;
      cnt       <= '0;
      acc       <= '0;
      opd       <= '0;
      neg       <= 1'b0;
      MdResultE <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        fn3 <= Fn3E;
        cnt <= CW'(W);
        neg <= neg_lat;
        acc <= {{W{1'b0}}, (is_div ? mag1 : mag2)};
        opd <= is_div ? mag2 : mag1;
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        acc <= fn3[2] ? acc_div : acc_mul;
      end
      if (state == SIGN && !FlushE) MdResultE <= res_sel;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes the expected result,
// a monitor pops and compares on every DoneE pulse.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   fn3 = 3'b000;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         stall, done;
  logic [W-1:0] res;

  muldiv_seq #(.DATA_WIDTH(W)) dut (
    .CPU_CLK  (clk),
    .CPU_RST  (rst_n),
    .StartE   (start),
    .Fn3E     (fn3),
    .Op1E     (op1),
    .Op2E     (op2),
    .FlushE   (flush),
    .StallMdE (stall),
    .DoneE    (done),
    .MdResultE(res)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ndone = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      prev_done_cyc = done_cyc;
      done_cyc      = cyc;
      ndone++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_without_request: got DoneE with result %h, expected no DoneE", res);
      end else begin
        check("result", res, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expv, input bit b2b);
    int t0, n0;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    exp_q.push_back(expv);
    n0 = ndone;
    start = 1'b1; fn3 = f; op1 = a; op2 = b;
    t0 = cyc;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      check($sformatf("stall_T+%0d", k), W'(stall), W'(k < 34));
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b0; fn3 = ~f; op1 = $urandom; op2 = $urandom;
      end
    end
    for (int i = 0; i < 60 && ndone == n0; i++) @(posedge clk);
    check("done_seen", W'(ndone - n0), 1);
    if (ndone == n0) exp_q.delete();
    check("latency", W'(done_cyc - t0), 34);
  endtask

  task automatic abort_op(input bit use_rst, input logic [W-1:0] hold);
    int n0;
    @(posedge clk);
    #1;
    n0 = ndone;
    start = 1'b1; fn3 = 3'b100; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst_n = 1'b0;
    else         flush = 1'b1;
    @(negedge clk);
    check("abort_stall_T10", W'(stall), 0);
    check("abort_done_T10", W'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    check("abort_stall_T11", W'(stall), 0);
    check("abort_result_T11", res, hold);
    repeat (40) @(posedge clk);
    check("abort_no_done", W'(ndone - n0), 0);
    check("abort_result_late", res, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with StartE asserted: no stall, no done, result cleared
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", W'(stall), 0);
    check("rst_done", W'(done), 0);
    check("rst_result", res, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;

    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0); // MUL 7*-3
    issue(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0); // MULH
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); // MULHSU
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0); // MULHU
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0); // DIV -7/2
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0); // REM -7/2
    issue(3'b101, 32'd100,       32'd7,         32'd14,        1'b0); // DIVU
    issue(3'b111, 32'd100,       32'd7,         32'd2,         1'b0); // REMU
    issue(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0); // DIV /0
    issue(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0); // REM -5/0
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); // DIV overflow
    abort_op(1'b0, 32'h8000_0000);                                    // flush keeps result
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0); // REM overflow
    issue(3'b111, 32'd5,         32'd0,         32'd5,         1'b0); // REMU 5/0
    abort_op(1'b1, 32'h0000_0000);                                    // reset clears result

    // Back-to-back: second StartE in the IDLE cycle right after DONE
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU
    issue(3'b101, 32'd1000,      32'd3,         32'd333,       1'b1); // DIVU
    check("b2b_spacing", W'(done_cyc - prev_done_cyc), 35);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the RV32M extension in the EX stage of the RISC-V pipeline CPU. The ControlUnit flags an M-type R-format instruction (Op 0110011, Fn7 0000001). This block latches the operands and runs a one-bit-per-cycle shift-add multiply or restoring divide. It holds the pipeline through a stall line to the hazard unit and presents a registered 32-bit result for the EX/MEM register.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- CPU_CLK  in  1  clock; all state changes on the rising edge.
- CPU_RST  in  1  reset, synchronous, active-low; state is cleared on a rising edge where CPU_RST==0.
- StartE  in  1  an M-extension instruction is valid in EX (decoded from Op/Fn7).
- Fn3E  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Op1E  in  DATA_WIDTH  rs1 value after forwarding.
- Op2E  in  DATA_WIDTH  rs2 value after forwarding.
- FlushE  in  1  EX flush from hazard unit; aborts any operation.
- StallMdE  out  1  hold IF/ID/EX (combinational).
- DoneE  out  1  one-cycle pulse; MdResultE valid.
- MdResultE  out  DATA_WIDTH  registered result.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: on StartE & !FlushE, latch the following and go to CALC:
  - Fn3E.
  - Operand magnitudes, with abs() applied to signed operands: Op1 for MULH/MULHSU/DIV/REM, Op2 for MULH/DIV/REM.
  - A negate flag: sign(Op1)^sign(Op2) for product/quotient, sign(Op1) for remainder. MUL uses raw bits, so the low word is sign-agnostic and no fix is needed.
  - Counter = DATA_WIDTH.
- CALC, multiply: 2*DATA_WIDTH accumulator; each cycle, if multiplier LSB is 1, add multiplicand into the upper half, then shift right one. Counter decrements; at 1, go to SIGN.
- CALC, divide: restoring. Each cycle, shift {rem,quot} left 1; if rem >= divisor, rem -= divisor and set quot LSB. Counter rule is the same as multiply.
- SIGN: two's-complement negate the 64-bit product, quotient or remainder if the flag is set. Select output:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Load MdResultE, then go to DONE.
- Divide by zero (Op2==0, detected at latch), no sign fix:
  - DIV/DIVU: result 0xFFFFFFFF.
  - REM/REMU: result Op1 unchanged.
- Signed overflow (DIV/REM 0x80000000 / 0xFFFFFFFF): the normal datapath yields quotient 0x80000000, remainder 0. This must hold; no special path.
- DONE: DoneE=1, go to IDLE.
- StallMdE = (IDLE & StartE & !FlushE) | CALC | SIGN. It is 0 in DONE, so the instruction advances with the result. In the following IDLE cycle a back-to-back M instruction starts a fresh operation.
- FlushE=1 in any state: go to IDLE next edge, StallMdE=0 that cycle, no DoneE, MdResultE unchanged.
- MdResultE holds its value until the next SIGN state.
- Reset values:
  - State IDLE, counter 0, accumulators 0, flags 0.
  - MdResultE 0, DoneE 0.
  - StallMdE is 0 while CPU_RST==0, regardless of StartE.

## Timing
- StartE is sampled at the edge ending cycle T.
- CALC occupies T+1..T+DATA_WIDTH, SIGN T+DATA_WIDTH+1, DONE T+DATA_WIDTH+2.
- Latency: DoneE in cycle T+34 for DATA_WIDTH=32. This is fixed for all eight ops, including divide-by-zero.
- StallMdE is high in cycles T..T+33 (34 cycles) and low at T+34.
- MdResultE changes only at the edge ending SIGN, and is stable from DONE onward.
- Reset asserted mid-operation: IDLE next edge; no DoneE, StallMdE low.
- Inputs Op1E/Op2E/Fn3E are ignored after the latch cycle; the pipeline is stalled, but the block does not rely on that.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> MdResultE=0xFFFFFFEB. DoneE at T+34, StallMdE high exactly T..T+33.
- MULH / MULHSU / MULHU with 0x80000000 × 0xFFFFFFFF, one run each -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Edge cases:
  - DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Abort: FlushE at T+10 -> IDLE at T+11, StallMdE 0 at T+10, no DoneE, MdResultE unchanged.
- Same abort with CPU_RST=0 at T+10 instead -> same response, and MdResultE=0.
- Back-to-back: DONE cycle followed by a new StartE -> second DoneE exactly 35 cycles after the first, each with the correct result.
